// File: rtl/cordic_share_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : cordic_share_ctrl_pkg
// Brief  : Shared types for the two-requester CORDIC sharing controller.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cordic_share_ctrl_pkg;

    localparam int NUM_REQ = 2;
    localparam int FLAG_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DELIVER = 3'd4
    } state_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic tmo;
    } flags_t;

    function automatic logic [NUM_REQ-1:0] idx2oh(input logic idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_share_ctrl_arbiter.sv
//------------------------------------------------------------------------------
// Module : cordic_rr_arbiter
// Brief  : Two-way round-robin winner select with registered priority pointer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cordic_rr_arbiter
    import cordic_share_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_upd,
    input  logic               i_owner,
    output logic               o_valid,
    output logic               o_idx
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (i_upd) begin
            ptr_d = ~i_owner;
        end

        // Pointer's index wins ties; otherwise the only requester wins.
        o_valid = |i_req;
        o_idx   = ptr_q;
        if (!i_req[ptr_q]) begin
            o_idx = ~ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cordic_share_ctrl.sv
//------------------------------------------------------------------------------
// Module : cordic_share_ctrl
// Brief  : Shares one CORDIC engine between two requesters, with timeout abort.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cordic_share_ctrl
    import cordic_share_ctrl_pkg::*;
#(
    parameter int W   = 32,
    parameter int TMO = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [1:0]   op,
    input  logic [W-1:0] data_in_0,
    input  logic [W-1:0] data_in_1,
    input  logic [1:0]   region_0,
    input  logic [1:0]   region_1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    input  logic [1:0]   ack_in,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         unf,
    output logic         tmo_err,
    output logic         beg_fsm_cordic,
    output logic         ack_cordic,
    output logic         operation,
    output logic [W-1:0] data_cordic,
    output logic [1:0]   shift_region_flag,
    input  logic         ready_cordic,
    input  logic [W-1:0] data_output,
    input  logic         overflow_flag,
    input  logic         underflow_flag
);

    localparam int CW = $clog2(TMO + 1);

    state_e        state_q,  state_d;
    logic          owner_q,  owner_d;
    logic [1:0]    gnt_q,    gnt_d;
    logic [1:0]    done_q,   done_d;
    logic [W-1:0]  result_q, result_d;
    flags_t        flags_q,  flags_d;
    logic          beg_q,    beg_d;
    logic          ack_q,    ack_d;
    logic          op_q,     op_d;
    logic [W-1:0]  data_q,   data_d;
    logic [1:0]    region_q, region_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [CW-1:0] cnt_inc;

    logic          win_valid;
    logic          win_idx;
    logic          ptr_upd;

    cordic_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (req),
        .i_upd   (ptr_upd),
        .i_owner (owner_q),
        .o_valid (win_valid),
        .o_idx   (win_idx)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        gnt_d    = 2'b00;
        done_d   = done_q;
        result_d = result_q;
        flags_d  = flags_q;
        beg_d    = 1'b0;
        ack_d    = ack_q;
        op_d     = op_q;
        data_d   = data_q;
        region_d = region_q;
        cnt_d    = cnt_q;
        ptr_upd  = 1'b0;
        cnt_inc  = cnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                // Grant and CORDIC start pulse appear together in START.
                if (win_valid) begin
                    owner_d  = win_idx;
                    gnt_d    = idx2oh(win_idx);
                    beg_d    = 1'b1;
                    op_d     = op[win_idx];
                    data_d   = win_idx ? data_in_1 : data_in_0;
                    region_d = win_idx ? region_1 : region_0;
                    result_d = '0;
                    flags_d  = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready_cordic) begin
                    result_d    = data_output;
                    flags_d.ovf = overflow_flag;
                    flags_d.unf = underflow_flag;
                    flags_d.tmo = 1'b0;
                    ack_d       = 1'b1;
                    state_d     = ST_RELEASE;
                end else if (cnt_inc == CW'(TMO)) begin
                    result_d    = '0;
                    flags_d     = '0;
                    flags_d.tmo = 1'b1;
                    ack_d       = 1'b1;
                    cnt_d       = cnt_inc;
                    state_d     = ST_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (!ready_cordic) begin
                    ack_d   = 1'b0;
                    done_d  = idx2oh(owner_q);
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (ack_in[owner_q]) begin
                    done_d  = 2'b00;
                    ptr_upd = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            result_q <= '0;
            flags_q  <= '0;
            beg_q    <= 1'b0;
            ack_q    <= 1'b0;
            op_q     <= 1'b0;
            data_q   <= '0;
            region_q <= 2'b00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            beg_q    <= beg_d;
            ack_q    <= ack_d;
            op_q     <= op_d;
            data_q   <= data_d;
            region_q <= region_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt               = gnt_q;
    assign done              = done_q;
    assign result            = result_q;
    assign ovf               = flags_q.ovf;
    assign unf               = flags_q.unf;
    assign tmo_err           = flags_q.tmo;
    assign beg_fsm_cordic    = beg_q;
    assign ack_cordic        = ack_q;
    assign operation         = op_q;
    assign data_cordic       = data_q;
    assign shift_region_flag = region_q;

endmodule

`default_nettype wire
